// File: rtl/deflate_out_writer.sv
// Purpose: buffers 512-bit compressed lines from the deflate core and issues one host write per line
//          at consecutive cache-line addresses from a programmable base, then reports done once
//          upstream has finished and every issued write has been acknowledged.
// Latency: a line pushed at edge N is popped at edge N+1, so wr_req_valid is high in the following cycle.
// Backpressure: wr_req_almost_full holds off issue. almost_full is an advisory stall hint to upstream.
//               Lines arriving while the FIFO is full or the line limit is reached are dropped and flagged.
// Ports: clk/rst (sync, active-high); start/base_addr/max_lines configure a job; finish marks end of input;
//        in_valid/in_data are the line stream; wr_req_* form the host write channel; wr_rsp_valid acks;
//        lines_written/lines_acked, overflow, limit_hit and done report status.
module deflate_out_writer #(
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = 42,
    parameter int AFULL_THRESH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       max_lines,
    input  logic              finish,
    input  logic              in_valid,
    input  logic [511:0]      in_data,
    output logic              almost_full,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [511:0]      wr_req_data,
    input  logic              wr_req_almost_full,
    input  logic              wr_rsp_valid,
    output logic [31:0]       lines_written,
    output logic [31:0]       lines_acked,
    output logic              overflow,
    output logic              limit_hit,
    output logic              done
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);
    localparam logic [PW:0] AF_LVL   = (PW+1)'(DEPTH - AFULL_THRESH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic [511:0]      mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       max_q, accepted_q, written_q, acked_q;
    logic              af_q, req_vld_q, ovf_q, lim_q, done_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [511:0]      req_dat_q;

    logic full, limit, in_run, push, pop, ovf_set, lim_set, ack_inc, restart;

    always_comb begin
        full    = (count_q == FULL_LVL);
        limit   = (accepted_q >= max_q);
        in_run  = (state_q == S_RUN);
        // Limit takes priority over full when deciding which sticky flag a dropped line sets.
        push    = in_valid && in_run && !full && !limit;
        ovf_set = in_valid && in_run && full && !limit;
        lim_set = in_valid && in_run && limit;
        pop     = (in_run || state_q == S_DRAIN) && (count_q != '0) && !wr_req_almost_full;
        // Acks beyond the number of issued writes are spurious and are not counted.
        ack_inc = wr_rsp_valid && (acked_q != written_q) && (acked_q != 32'hFFFF_FFFF);
        restart = start && (state_q == S_IDLE || state_q == S_DONE);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Line storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            base_q     <= '0;
            max_q      <= '0;
            accepted_q <= '0;
            written_q  <= '0;
            acked_q    <= '0;
            af_q       <= 1'b0;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            req_dat_q  <= '0;
            ovf_q      <= 1'b0;
            lim_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            req_vld_q <= pop;
            count_q   <= count_d;
            af_q      <= (count_d >= AF_LVL);

            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PW'(1);
                accepted_q <= (accepted_q == 32'hFFFF_FFFF) ? accepted_q : accepted_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PW'(1);
                req_dat_q  <= mem_q[rd_ptr_q];
                // Address wraps modulo 2^ADDR_W by construction of the adder width.
                req_addr_q <= base_q + ADDR_W'(written_q);
                written_q  <= (written_q == 32'hFFFF_FFFF) ? written_q : written_q + 32'd1;
            end
            if (ack_inc) begin
                acked_q <= acked_q + 32'd1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            if (lim_set) begin
                lim_q <= 1'b1;
            end

            case (state_q)
                S_RUN: begin
                    if (finish) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (count_q == '0 && acked_q == written_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE only react to start, handled below.
                end
            endcase

            // A new job overrides the counter and flag updates above.
            if (restart) begin
                state_q    <= S_RUN;
                done_q     <= 1'b0;
                base_q     <= base_addr;
                max_q      <= max_lines;
                accepted_q <= '0;
                written_q  <= '0;
                acked_q    <= '0;
                ovf_q      <= 1'b0;
                lim_q      <= 1'b0;
            end
        end
    end

    assign almost_full   = af_q;
    assign wr_req_valid  = req_vld_q;
    assign wr_req_addr   = req_addr_q;
    assign wr_req_data   = req_dat_q;
    assign lines_written = written_q;
    assign lines_acked   = acked_q;
    assign overflow      = ovf_q;
    assign limit_hit     = lim_q;
    assign done          = done_q;

endmodule

// File: tb/tb_deflate_out_writer.sv
module tb_deflate_out_writer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [41:0]   base_addr;
    logic [31:0]   max_lines;
    logic          finish;
    logic          in_valid;
    logic [511:0]  in_data;
    logic          almost_full;
    logic          wr_req_valid;
    logic [41:0]   wr_req_addr;
    logic [511:0]  wr_req_data;
    logic          wr_req_almost_full;
    logic          wr_rsp_valid;
    logic [31:0]   lines_written;
    logic [31:0]   lines_acked;
    logic          overflow;
    logic          limit_hit;
    logic          done;

    deflate_out_writer #(.DEPTH(64), .ADDR_W(42), .AFULL_THRESH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .max_lines(max_lines),
        .finish(finish), .in_valid(in_valid), .in_data(in_data), .almost_full(almost_full),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_almost_full(wr_req_almost_full), .wr_rsp_valid(wr_rsp_valid),
        .lines_written(lines_written), .lines_acked(lines_acked), .overflow(overflow),
        .limit_hit(limit_hit), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [41:0]  addr;
        logic [511:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [511:0] mk(int k);
        logic [31:0] w;
        w = 32'hDEAD_0000 | 32'(k);
        return {16{w}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [41:0] b, input logic [31:0] m);
        start = 1'b1; base_addr = b; max_lines = m;
        tick();
        start = 1'b0;
    endtask

    // Drives one line; if 'keep' the expected request (address a) is queued for the monitor.
    task automatic push_line(input logic [511:0] d, input logic fin, input bit keep, input logic [41:0] a);
        in_valid = 1'b1; in_data = d; finish = fin;
        if (keep) exp_q.push_back('{addr: a, data: d});
        tick();
        in_valid = 1'b0; finish = 1'b0;
    endtask

    task automatic send_acks(input int n);
        for (int i = 0; i < n; i++) begin
            wr_rsp_valid = 1'b1;
            tick();
        end
        wr_rsp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 200) begin
            tick();
            k++;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    // Scoreboard monitor: every presented request must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && wr_req_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr_req: got addr %0h, required no request", wr_req_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.addr !== wr_req_addr || mon_e.data !== wr_req_data) begin
                    errors++;
                    $display("FAIL wr_req: got addr %0h data[31:0] %0h, required addr %0h data[31:0] %0h",
                             wr_req_addr, wr_req_data[31:0], mon_e.addr, mon_e.data[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; max_lines = '0; finish = 1'b0;
        in_valid = 1'b0; in_data = '0; wr_req_almost_full = 1'b0; wr_rsp_valid = 1'b0;
        idle(3);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_wr_req_valid", 64'(wr_req_valid), 64'd0);
        chk("rst_lines_written", 64'(lines_written), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // Basic ordering, one-cycle latency, finish with the 4th line, ack tracking.
        do_start(42'h100, 32'd1000);
        push_line(mk(10), 1'b0, 1, 42'h100);
        push_line(mk(11), 1'b0, 1, 42'h101);
        chk("latency_valid", 64'(wr_req_valid), 64'd1);
        chk("latency_addr", 64'(wr_req_addr), 64'h100);
        push_line(mk(12), 1'b0, 1, 42'h102);
        idle(2);
        chk("basic_lines_written", 64'(lines_written), 64'd3);
        push_line(mk(13), 1'b1, 1, 42'h103);
        idle(3);
        chk("drain_lines_written", 64'(lines_written), 64'd4);
        send_acks(3);
        idle(4);
        chk("drain_not_done", 64'(done), 64'd0);
        send_acks(1);
        tick();
        chk("done_after_last_ack", 64'(done), 64'd1);
        send_acks(1);
        tick();
        chk("spurious_ack_ignored", 64'(lines_acked), 64'd4);

        // Host back-pressure, almost_full threshold and overflow drops.
        do_start(42'h2000, 32'd1000);
        wr_req_almost_full = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            push_line(mk(100 + i), 1'b0, (i <= 64), 42'h2000 + 42'(i - 1));
            if (i == 55) chk("af_below_thresh", 64'(almost_full), 64'd0);
            if (i == 56) chk("af_at_thresh", 64'(almost_full), 64'd1);
        end
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_no_limit", 64'(limit_hit), 64'd0);
        chk("stalled_no_issue", 64'(lines_written), 64'd0);
        wr_req_almost_full = 1'b0;
        idle(70);
        chk("ovf_lines_written", 64'(lines_written), 64'd64);
        finish = 1'b1; tick(); finish = 1'b0;
        send_acks(64);
        wait_done("ovf_done");

        // max_lines limit.
        do_start(42'h300, 32'd2);
        push_line(mk(201), 1'b0, 1, 42'h300);
        push_line(mk(202), 1'b0, 1, 42'h301);
        push_line(mk(203), 1'b0, 0, 42'h0);
        idle(3);
        chk("limit_hit", 64'(limit_hit), 64'd1);
        chk("limit_no_ovf", 64'(overflow), 64'd0);
        chk("limit_lines_written", 64'(lines_written), 64'd2);
        finish = 1'b1; tick(); finish = 1'b0;
        send_acks(2);
        wait_done("limit_done");

        // Address wrap at the top of the address space.
        do_start(42'h3FF_FFFF_FFFF, 32'd10);
        push_line(mk(301), 1'b0, 1, 42'h3FF_FFFF_FFFF);
        push_line(mk(302), 1'b1, 1, 42'h0);
        idle(3);
        send_acks(2);
        wait_done("wrap_done");

        // Reset with lines queued, then a fresh job.
        do_start(42'h500, 32'd100);
        wr_req_almost_full = 1'b1;
        for (int i = 0; i < 10; i++) push_line(mk(400 + i), 1'b0, 0, 42'h0);
        send_acks(1);
        exp_q.delete();
        rst = 1'b1;
        wr_req_almost_full = 1'b0;
        tick();
        chk("midrst_wr_req_valid", 64'(wr_req_valid), 64'd0);
        chk("midrst_wr_req_data", 64'(|wr_req_data), 64'd0);
        chk("midrst_wr_req_addr", 64'(wr_req_addr), 64'd0);
        chk("midrst_lines_acked", 64'(lines_acked), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        idle(20);
        chk("postrst_lines_written", 64'(lines_written), 64'd0);
        do_start(42'h40, 32'd5);
        push_line(mk(500), 1'b1, 1, 42'h40);
        idle(3);
        send_acks(1);
        wait_done("fresh_done");
        chk("fresh_lines_acked", 64'(lines_acked), 64'd1);

        idle(2);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
